// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // The digit counter needs at least one bit, even when a single digit covers the word.
    function automatic int cnt_width(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// Combinational N-bit ripple slice; also exposes the carry into its top bit
// so the caller can form signed overflow on the final digit.
module adder_digit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    logic carry;

    always_comb begin
        carry = cin;
        cmsb  = cin;
        s     = '0;
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) begin
                cmsb = carry;
            end
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial two's-complement adder/subtractor: one DIGIT-bit slice reused
// over WIDTH/DIGIT cycles, least-significant digit first, start/done handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int D  = WIDTH / DIGIT;
    localparam int CW = cnt_width(D);

    state_t            state_q;
    logic [WIDTH-1:0]  areg_q, breg_q, res_q, s_q;
    logic [CW-1:0]     cnt_q;
    logic              carry_q, busy_q, done_q, cout_q, ovf_q;

    logic [DIGIT-1:0]  dig_sum;
    logic              dig_cout, dig_cmsb;
    logic [WIDTH-1:0]  res_d, areg_d, breg_d;
    logic              last_digit;

    adder_digit #(.N(DIGIT)) u_digit (
        .a    (areg_q[DIGIT-1:0]),
        .b    (breg_q[DIGIT-1:0]),
        .cin  (carry_q),
        .s    (dig_sum),
        .cout (dig_cout),
        .cmsb (dig_cmsb)
    );

    // New digit enters from the MSB side, so after D shifts digit 0 sits at the bottom.
    assign res_d      = WIDTH'({dig_sum, res_q} >> DIGIT);
    assign areg_d     = areg_q >> DIGIT;
    assign breg_d     = breg_q >> DIGIT;
    assign last_digit = (cnt_q == CW'(D - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            areg_q  <= '0;
            breg_q  <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        areg_q  <= a;
                        breg_q  <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    carry_q <= dig_cout;
                    areg_q  <= areg_d;
                    breg_q  <= breg_d;
                    res_q   <= res_d;
                    if (last_digit) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        s_q     <= res_d;
                        cout_q  <= dig_cout;
                        ovf_q   <= dig_cmsb ^ dig_cout;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8, DIGIT=2): stimulus pushes expected
// results, a negedge monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_serial_adder;

    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int D     = WIDTH / DIGIT;
    localparam int LAT   = D + 1;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             ovf;
        int               due;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             cin, sub;
    logic             busy, done, cout, ovf;
    logic [WIDTH-1:0] s;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;

    serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done cyc=%0d s=%h cout=%b ovf=%b", cyc, s, cout, ovf);
            end else begin
                mon_e = sb.pop_front();
                $display("txn cyc=%0d s=%h cout=%b ovf=%b (want s=%h cout=%b ovf=%b at cyc %0d)",
                         cyc, s, cout, ovf, mon_e.s, mon_e.cout, mon_e.ovf, mon_e.due);
                if (s !== mon_e.s || cout !== mon_e.cout || ovf !== mon_e.ovf) begin
                    errors++;
                    $display("FAIL result got s=%h cout=%b ovf=%b want s=%h cout=%b ovf=%b",
                             s, cout, ovf, mon_e.s, mon_e.cout, mon_e.ovf);
                end
                checks++;
                if (cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL latency done at cyc %0d want cyc %0d", cyc, mon_e.due);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] es, input logic ec, input logic eo, input int due);
        exp_t e;
        e.s = es; e.cout = ec; e.ovf = eo; e.due = due;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 4 * LAT; i++) begin
            if (done_cnt >= target) return;
            @(negedge clk); #1;
        end
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL done_timeout got %0d dones want %0d", done_cnt, target);
        end
    endtask

    task automatic do_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                         input logic xc, input logic xs,
                         input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        int base;
        @(negedge clk);
        base  = done_cnt;
        a     = xa; b = xb; cin = xc; sub = xs; start = 1'b1;
        push_exp(es, ec, eo, cyc + LAT);
        @(negedge clk);
        start = 1'b0;
        wait_done(base + 1);
    endtask

    // Independent reference: full-width add, signed overflow from operand/result signs.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                                               input logic xc, input logic xs);
        logic [WIDTH:0] r;
        logic           o;
        if (xs) begin
            r = {1'b0, xa} + {1'b0, ~xb} + 1;
            o = (xa[WIDTH-1] != xb[WIDTH-1]) && (r[WIDTH-1] != xa[WIDTH-1]);
        end else begin
            r = {1'b0, xa} + {1'b0, xb} + {{WIDTH{1'b0}}, xc};
            o = (xa[WIDTH-1] == xb[WIDTH-1]) && (r[WIDTH-1] != xa[WIDTH-1]);
        end
        return {o, r};
    endfunction

    initial begin
        int            base;
        logic [WIDTH+1:0] m;
        logic [WIDTH-1:0] ra, rb;
        logic          rc, rs;

        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        chk("por_busy", busy, 0);
        chk("por_done", done, 0);
        chk("por_s",    s,    0);
        chk("por_cout", cout, 0);
        chk("por_ovf",  ovf,  0);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors with hand-computed results
        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        do_op(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
        do_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        do_op(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        do_op(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);

        // start pulsed mid-RUN must be ignored
        @(negedge clk);
        base = done_cnt;
        a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; start = 1'b1;
        push_exp(8'h03, 1'b0, 1'b0, cyc + LAT);
        @(negedge clk);
        start = 1'b0;
        chk("busy_in_run", busy, 1);
        @(negedge clk);
        a = 8'h11; b = 8'h22; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(base + 1);
        repeat (8) @(negedge clk);
        chk("single_done", done_cnt, base + 1);
        chk("held_s", s, 8'h03);

        // Back-to-back: start held through DONE accepts the second operation
        @(negedge clk);
        base = done_cnt;
        a = 8'h33; b = 8'h44; cin = 1'b0; sub = 1'b0; start = 1'b1;
        push_exp(8'h77, 1'b0, 1'b0, cyc + LAT);
        push_exp(8'h80, 1'b1, 1'b0, cyc + 2 * LAT);
        @(negedge clk);
        a = 8'hC0; b = 8'h40; sub = 1'b1;
        repeat (LAT) @(negedge clk);
        start = 1'b0;
        wait_done(base + 2);
        repeat (3) @(negedge clk);
        chk("b2b_dones", done_cnt, base + 2);
        chk("b2b_held_s", s, 8'h80);
        chk("b2b_held_cout", cout, 1);

        // Reset while cnt==2 aborts with no done
        @(negedge clk);
        base = done_cnt;
        a = 8'h5A; b = 8'h3C; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_s",    s,    0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf",  ovf,  0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("rst_no_done", done_cnt, base);

        // Random operations against the reference model
        for (int n = 0; n < 5000; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            m  = model(ra, rb, rc, rs);
            do_op(ra, rb, rc, rs, m[WIDTH-1:0], m[WIDTH], m[WIDTH+1]);
        end

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
